// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised 2R/1W register file with per-register busy scoreboard
// Optional macro RF_BYPASS_EN: same-cycle write-through forwarding to both read ports.
module regfile_scoreboard #(
    parameter int DW      = 16,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] ADD1,
    input  logic [AW-1:0] ADD2,
    output logic [DW-1:0] R1,
    output logic [DW-1:0] R2,
    output logic          BUSY1,
    output logic          BUSY2,
    input  logic          WEN,
    input  logic [AW-1:0] WADD,
    input  logic [DW-1:0] DATAIN,
    input  logic          RSV,
    input  logic [AW-1:0] RSVADD,
    output logic [AW:0]   PENDING,
    output logic          ERR
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0]   regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     pending_q, pending_d;
    logic            err_q, err_d;

    logic wen_eff, rsv_eff;
    logic rd1_zero, rd2_zero;

    // Accesses to a hardwired R0 are dropped before they touch any state.
    assign wen_eff  = WEN && !((ZERO_R0 != 0) && (WADD == '0));
    assign rsv_eff  = RSV && !((ZERO_R0 != 0) && (RSVADD == '0));
    assign rd1_zero = (ZERO_R0 != 0) && (ADD1 == '0);
    assign rd2_zero = (ZERO_R0 != 0) && (ADD2 == '0);

    always_comb begin
        busy_d    = busy_q;
        err_d     = err_q;
        pending_d = '0;
        if (rsv_eff && busy_q[RSVADD] && !(wen_eff && (WADD == RSVADD))) begin
            err_d = 1'b1;
        end
        // Reserve is applied after the write so a same-address pair ends busy.
        if (wen_eff) begin
            busy_d[WADD] = 1'b0;
        end
        if (rsv_eff) begin
            busy_d[RSVADD] = 1'b1;
        end
        for (int i = 0; i < NREG; i++) begin
            pending_d = pending_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (wen_eff) begin
                regs_q[WADD] <= DATAIN;
            end
            busy_q    <= busy_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        R1    = regs_q[ADD1];
        BUSY1 = busy_q[ADD1];
        R2    = regs_q[ADD2];
        BUSY2 = busy_q[ADD2];
`ifdef RF_BYPASS_EN
        if (wen_eff && (WADD == ADD1)) begin
            R1    = DATAIN;
            BUSY1 = 1'b0;
        end
        if (wen_eff && (WADD == ADD2)) begin
            R2    = DATAIN;
            BUSY2 = 1'b0;
        end
`endif
        if (rd1_zero) begin
            R1    = '0;
            BUSY1 = 1'b0;
        end
        if (rd2_zero) begin
            R2    = '0;
            BUSY2 = 1'b0;
        end
    end

    assign PENDING = pending_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed plus random bench for regfile_scoreboard against an array model
module tb_regfile_scoreboard;

    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int NREG = 8;

    logic          CLK = 1'b0;
    logic          RST, WEN, RSV;
    logic [AW-1:0] ADD1, ADD2, WADD, RSVADD;
    logic [DW-1:0] DATAIN, R1, R2;
    logic          BUSY1, BUSY2, ERR;
    logic [AW:0]   PENDING;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] m_reg  [NREG];
    bit            m_busy [NREG];
    bit            m_err;

    regfile_scoreboard #(.DW(DW), .AW(AW), .ZERO_R0(1)) dut (
        .CLK(CLK), .RST(RST), .ADD1(ADD1), .ADD2(ADD2), .R1(R1), .R2(R2),
        .BUSY1(BUSY1), .BUSY2(BUSY2), .WEN(WEN), .WADD(WADD), .DATAIN(DATAIN),
        .RSV(RSV), .RSVADD(RSVADD), .PENDING(PENDING), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] exp_r(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (WEN && WADD == a) return DATAIN;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (WEN && WADD == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic int exp_pending();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set(input logic rst, input logic wen, input logic [AW-1:0] wadd,
                       input logic [DW-1:0] din, input logic rsv, input logic [AW-1:0] radd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        RST = rst; WEN = wen; WADD = wadd; DATAIN = din;
        RSV = rsv; RSVADD = radd; ADD1 = a1; ADD2 = a2;
    endtask

    // Compare every output against the model just before the rising edge.
    task automatic check_now();
        @(negedge CLK);
        chk("R1", R1, exp_r(ADD1));
        chk("R2", R2, exp_r(ADD2));
        chk("BUSY1", BUSY1, exp_busy(ADD1));
        chk("BUSY2", BUSY2, exp_busy(ADD2));
        chk("PENDING", PENDING, exp_pending());
        chk("ERR", ERR, m_err);
    endtask

    task automatic clock_edge();
        bit w, r;
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                m_reg[i] = '0;
                m_busy[i] = 0;
            end
            m_err = 0;
        end else begin
            w = WEN && WADD != 0;
            r = RSV && RSVADD != 0;
            if (r && m_busy[RSVADD] && !(w && WADD == RSVADD)) m_err = 1;
            if (w) begin
                m_reg[WADD] = DATAIN;
                m_busy[WADD] = 0;
            end
            if (r) m_busy[RSVADD] = 1;
        end
        #1;
    endtask

    task automatic cyc();
        check_now();
        clock_edge();
    endtask

    initial begin
        set(1, 0, 0, 0, 0, 0, 0, 0);
        clock_edge();
        cyc();
        for (int i = 0; i < NREG; i++) begin
            set(0, 0, 0, 0, 0, 0, AW'(i), AW'(NREG - 1 - i));
            check_now();
            chk("init_r1", R1, 0);
            chk("init_busy1", BUSY1, 0);
            clock_edge();
        end

        set(0, 1, 3, 16'hA5A5, 0, 0, 0, 0); cyc();
        set(0, 1, 7, 16'h1234, 0, 0, 0, 0); cyc();
        set(0, 0, 0, 0, 0, 0, 3, 7);
        check_now();
        chk("rd_reg3", R1, 16'hA5A5);
        chk("rd_reg7", R2, 16'h1234);
        clock_edge();
        set(0, 1, 0, 16'hFFFF, 0, 0, 0, 0); cyc();
        set(0, 0, 0, 0, 0, 0, 0, 0);
        check_now();
        chk("rd_r0_zero", R1, 0);
        clock_edge();

        set(0, 0, 0, 0, 1, 5, 5, 0); cyc();
        set(0, 0, 0, 0, 0, 0, 5, 0);
        check_now();
        chk("rsv5_busy", BUSY1, 1);
        chk("rsv5_pending", PENDING, 1);
        clock_edge();
        set(0, 1, 5, 16'h00FF, 0, 0, 0, 0); cyc();
        set(0, 0, 0, 0, 0, 0, 5, 0);
        check_now();
        chk("wr5_busy", BUSY1, 0);
        chk("wr5_data", R1, 16'h00FF);
        chk("wr5_pending", PENDING, 0);
        clock_edge();

        set(0, 1, 4, 16'h4444, 1, 4, 0, 0); cyc();
        set(0, 0, 0, 0, 0, 0, 4, 4);
        check_now();
        chk("wr_rsv4_data", R1, 16'h4444);
        chk("wr_rsv4_busy", BUSY2, 1);
        chk("wr_rsv4_err", ERR, 0);
        clock_edge();
        set(0, 0, 0, 0, 1, 2, 2, 0); cyc();
        set(0, 0, 0, 0, 1, 2, 2, 0); cyc();
        set(0, 1, 2, 16'h2222, 0, 0, 2, 1); cyc();
        set(0, 1, 1, 16'h0101, 0, 0, 1, 2);
        check_now();
        chk("err_sticky", ERR, 1);
        clock_edge();

        set(0, 1, 6, 16'hBEEF, 0, 0, 6, 6);
        check_now();
`ifdef RF_BYPASS_EN
        chk("bypass_same_cycle", R1, 16'hBEEF);
`else
        chk("no_bypass_old", R1, 16'h0000);
`endif
        clock_edge();
        set(0, 0, 0, 0, 0, 0, 6, 0);
        check_now();
        chk("after_wr6", R1, 16'hBEEF);
        clock_edge();

        set(1, 0, 0, 0, 0, 0, 0, 0); cyc();
        set(0, 0, 0, 0, 1, 1, 0, 0); cyc();
        set(0, 0, 0, 0, 1, 2, 0, 0); cyc();
        set(0, 0, 0, 0, 1, 2, 0, 0); cyc();
        set(0, 1, 7, 16'h7777, 1, 3, 0, 0); cyc();
        set(0, 0, 0, 0, 0, 0, 7, 3);
        check_now();
        chk("mid_pending3", PENDING, 3);
        chk("mid_err1", ERR, 1);
        clock_edge();
        set(1, 1, 5, 16'h5555, 1, 6, 0, 0); cyc();
        for (int i = 0; i < NREG; i++) begin
            set(0, 0, 0, 0, 0, 0, AW'(i), AW'(i));
            check_now();
            chk("post_rst_reg", R1, 0);
            chk("post_rst_pending", PENDING, 0);
            chk("post_rst_err", ERR, 0);
            clock_edge();
        end

        for (int n = 0; n < 400; n++) begin
            set(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, AW'($urandom),
                DW'($urandom), $urandom_range(0, 2) == 0, AW'($urandom),
                AW'($urandom), AW'($urandom));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the 8x16 two-read/one-write register file. Adds configurable width and depth, a synchronous reset, an optional hardwired-zero R0, and a per-register busy scoreboard with a reserve port. Sits between decode and the ALU/writeback stage: decode reserves a destination register, writeback writes it, and operand reads report whether a value is still pending.

Parameters:
DW, 16, data width in bits
AW, 3, address width; depth NREG = 2**AW
ZERO_R0, 1, when 1 register 0 always reads 0, ignores writes and never goes busy

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
ADD1  in  AW  read port 1 address
ADD2  in  AW  read port 2 address
R1  out  DW  read port 1 data
R2  out  DW  read port 2 data
BUSY1  out  1  register at ADD1 has an outstanding reservation
BUSY2  out  1  register at ADD2 has an outstanding reservation
WEN  in  1  write enable
WADD  in  AW  write address
DATAIN  in  DW  write data
RSV  in  1  reserve enable: mark RSVADD busy
RSVADD  in  AW  reserve address
PENDING  out  AW+1  count of busy registers
ERR  out  1  sticky double-reservation flag

Behaviour:
- One clock domain (CLK). RST is synchronous and active-high, sampled on the rising edge of CLK.
- On RST: all registers 0, all busy bits 0, PENDING 0, ERR 0. RST overrides WEN and RSV in the same cycle.
- Write: on a CLK edge with WEN=1, reg[WADD] <= DATAIN and busy[WADD] <= 0. Writing to a non-busy register is legal (used for initialisation).
- Reserve: on a CLK edge with RSV=1, busy[RSVADD] <= 1.
- Same address, same cycle, WEN=1 and RSV=1: data is written and busy ends at 1. The reservation is for the new producer, so reserve wins.
- ERR: set when RSV=1 targets a register that is already busy and no same-cycle WEN clears that address. ERR holds until RST.
- ZERO_R0=1: WEN or RSV with address 0 is ignored (no write, no busy, no ERR). Reads of address 0 return 0 and BUSY=0.
- Reads: combinational, zero latency. R1/R2 and BUSY1/BUSY2 reflect registered state, adjusted by forwarding (see Optional Feature).
- PENDING: registered popcount of the busy bits, updated on the same edge as the busy bits. Range 0..NREG (AW+1 bits, so no overflow).
- Both read ports may address the same register. Each port behaves independently and identically.
- X-free: all storage is reset. Outputs are never X after the first RST edge.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-through forwarding. When WEN=1 and WADD==ADDn (and not the zeroed R0), Rn=DATAIN and BUSYn=0 in the same cycle. A same-cycle RSV to that address does not raise BUSYn until the next cycle.
- Undefined: Rn and BUSYn show only stored state. New data and the cleared busy bit are visible one cycle after the write edge.

Test Plan:
- Reset/init: RST=1 for 2 cycles, then read all 8 addresses -> R1=R2=0x0000, BUSY1=BUSY2=0, PENDING=0, ERR=0.
- Write/read: write reg3=0xA5A5 and reg7=0x1234. Next cycle ADD1=3, ADD2=7 -> R1=0xA5A5, R2=0x1234. Write reg0=0xFFFF -> R1 with ADD1=0 reads 0x0000.
- Scoreboard: RSV reg5 -> next cycle BUSY1=1 (ADD1=5), PENDING=1. WEN reg5=0x00FF -> next cycle BUSY1=0, R1=0x00FF, PENDING=0.
- Conflicts: RSV reg2 twice with no write between -> ERR=1, held through further traffic until RST. Same-cycle WEN+RSV on reg4 -> reg4 written and busy=1, ERR stays 0.
- Bypass (RF_BYPASS_EN defined): ADD1=6, WEN=1, WADD=6, DATAIN=0xBEEF -> R1=0xBEEF in the same cycle. Undefined -> R1 shows the old value, then 0xBEEF after the edge.
- Mid-operation reset: with 3 registers busy (PENDING=3) and ERR=1, pulse RST one cycle alongside WEN/RSV -> next cycle PENDING=0, ERR=0, all registers 0.
